video_timing_gen: RTL and testbench

Generates raster timing for the video display path from the 27 MHz auxiliary pixel clock. Default timing is 720x480p CEA at 27 MHz.
Produces sync pulses, data-enable, raster position and frame/line strobes. The pixel/pattern stage downstream consumes these outputs.
Sits directly downstream of the board-level clock/reset top: it uses fpga_CLK_AUX and fpga_NRST from that top.

---
 rtl/video_pkg.sv | 44 ++++
 rtl/video_timing_gen_if.sv | 32 +++
 rtl/video_axis_counter.sv | 41 ++++
 rtl/video_timing_gen.sv | 91 +++++++++
 tb/tb_video_timing_gen.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared timing constants, position types and region encoding for the video
// raster generator. Defaults describe 720x480p CEA timing at 27 MHz.
package video_pkg;

  localparam int DEF_H_DISP  = 720;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_PW    = 62;
  localparam int DEF_H_BP    = 60;
  localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_PW + DEF_H_BP;

  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FP    = 9;
  localparam int DEF_V_PW    = 6;
  localparam int DEF_V_BP    = 30;
  localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_PW + DEF_V_BP;

  localparam int DEF_HPOS_W = $clog2(DEF_H_TOTAL);
  localparam int DEF_VPOS_W = $clog2(DEF_V_TOTAL);

  typedef logic [DEF_HPOS_W-1:0] hpos_t;
  typedef logic [DEF_VPOS_W-1:0] vpos_t;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_e;

  // Regions are laid out in order: active, front porch, sync, back porch.
  function automatic region_e region_of(int pos, int disp, int fp, int pw);
    region_e r;
    r = BACK;
    if (pos < disp) begin
      r = ACTIVE;
    end else if (pos < disp + fp) begin
      r = FRONT;
    end else if (pos < disp + fp + pw) begin
      r = SYNC;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel stage.
// en is a level run-enable driven by the consumer; all other signals are
// registered by the generator and valid on every cycle (no ready/back-pressure).
interface video_timing_gen_if #(
  parameter int HPOS_W = 10,
  parameter int VPOS_W = 10,
  parameter int FC_W   = 8
);

  logic              en;
  logic              video_HS;
  logic              video_VS;
  logic              video_DE;
  logic [HPOS_W-1:0] h_pos;
  logic [VPOS_W-1:0] v_pos;
  logic              line_start;
  logic              frame_start;
  logic [FC_W-1:0]   frame_count;

  modport master (
    input  en,
    output video_HS, video_VS, video_DE, h_pos, v_pos,
           line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  video_HS, video_VS, video_DE, h_pos, v_pos,
           line_start, frame_start, frame_count
  );

endinterface

// File: rtl/video_axis_counter.sv
// One raster axis: wrap counter with count-enable, terminal count and a
// decode of which timing region the current count lies in.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int DISP = DEF_H_DISP,
  parameter int FP   = DEF_H_FP,
  parameter int PW   = DEF_H_PW,
  parameter int BP   = DEF_H_BP,
  parameter int W    = $clog2(DISP + FP + PW + BP)
) (
  input  logic         fpga_CLK_AUX,
  input  logic         fpga_NRST,
  input  logic         cnt_en,
  output logic [W-1:0] count,
  output logic         tc,
  output region_e      region
);

  localparam int TOTAL = DISP + FP + PW + BP;

  if (DISP < 1 || FP < 1 || PW < 1 || BP < 1) begin : g_bad_timing
    $error("video_axis_counter: DISP/FP/PW/BP must all be >= 1");
  end

  if (W < $clog2(TOTAL)) begin : g_bad_width
    $error("video_axis_counter: W too narrow for DISP+FP+PW+BP");
  end

  assign tc     = (count == W'(TOTAL - 1));
  assign region = region_of(int'(count), DISP, FP, PW);

  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      count <= '0;
    end else if (cnt_en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: chains the horizontal wrap into the vertical count
// and registers every output from the pre-edge counter values.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_PW     = DEF_H_PW,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_PW     = DEF_V_PW,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int FC_W     = 8
) (
  input  logic               fpga_CLK_AUX,
  input  logic               fpga_NRST,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_DISP + H_FP + H_PW + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_PW + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          h_tc;
  logic          v_tc_unused;
  logic          at_origin;
  region_e       h_reg;
  region_e       v_reg;

  video_axis_counter #(
    .DISP(H_DISP), .FP(H_FP), .PW(H_PW), .BP(H_BP), .W(HW)
  ) u_h (
    .fpga_CLK_AUX(fpga_CLK_AUX),
    .fpga_NRST   (fpga_NRST),
    .cnt_en      (vid.en),
    .count       (hc),
    .tc          (h_tc),
    .region      (h_reg)
  );

  video_axis_counter #(
    .DISP(V_DISP), .FP(V_FP), .PW(V_PW), .BP(V_BP), .W(VW)
  ) u_v (
    .fpga_CLK_AUX(fpga_CLK_AUX),
    .fpga_NRST   (fpga_NRST),
    .cnt_en      (vid.en && h_tc),
    .count       (vc),
    .tc          (v_tc_unused),
    .region      (v_reg)
  );

  assign at_origin = (hc == '0) && (vc == '0);

  // While paused the position outputs keep the last displayed pixel, so the
  // first enabled output after a pause is the next pixel in raster order.
  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      vid.video_HS    <= ~SYNC_POL;
      vid.video_VS    <= ~SYNC_POL;
      vid.video_DE    <= 1'b0;
      vid.h_pos       <= '0;
      vid.v_pos       <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.frame_count <= '0;
    end else if (vid.en) begin
      vid.video_HS    <= (h_reg == SYNC) ? SYNC_POL : ~SYNC_POL;
      vid.video_VS    <= (v_reg == SYNC) ? SYNC_POL : ~SYNC_POL;
      vid.video_DE    <= (h_reg == ACTIVE) && (v_reg == ACTIVE);
      vid.h_pos       <= hc;
      vid.v_pos       <= vc;
      vid.line_start  <= (hc == '0);
      vid.frame_start <= at_origin;
      if (at_origin) begin
        vid.frame_count <= vid.frame_count + FC_W'(1);
      end
    end else begin
      vid.video_HS    <= ~SYNC_POL;
      vid.video_VS    <= ~SYNC_POL;
      vid.video_DE    <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-timing instance and a small-timing
// instance (H 8/2/2/2, V 4/1/2/1, 2-bit frame counter) run side by side.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int B_HD = 8, B_HF = 2, B_HP = 2, B_HB = 2;
  localparam int B_VD = 4, B_VF = 1, B_VP = 2, B_VB = 1;
  localparam int A_FT = DEF_H_TOTAL * DEF_V_TOTAL;
  localparam int B_FT = (B_HD + B_HF + B_HP + B_HB) * (B_VD + B_VF + B_VP + B_VB);

  typedef struct {
    int h;
    int v;
    bit de;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if #(.HPOS_W(10), .VPOS_W(10), .FC_W(8)) ifa ();
  video_timing_gen_if #(.HPOS_W(4), .VPOS_W(3), .FC_W(2)) ifb ();

  video_timing_gen dut_a (
    .fpga_CLK_AUX(clk),
    .fpga_NRST   (rst_a),
    .vid         (ifa)
  );

  video_timing_gen #(
    .H_DISP(B_HD), .H_FP(B_HF), .H_PW(B_HP), .H_BP(B_HB),
    .V_DISP(B_VD), .V_FP(B_VF), .V_PW(B_VP), .V_BP(B_VB),
    .SYNC_POL(1'b0), .FC_W(2)
  ) dut_b (
    .fpga_CLK_AUX(clk),
    .fpga_NRST   (rst_b),
    .vid         (ifb)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Raster position is just the count of enabled edges since reset, folded
  // into a frame; every output follows from that index by region arithmetic.
  function automatic exp_t decode(int pos, int hd, int hf, int hp, int hb,
                                  int vd, int vf, int vp);
    exp_t e;
    int ht;
    ht   = hd + hf + hp + hb;
    e.h  = pos % ht;
    e.v  = pos / ht;
    e.de = (e.h < hd) && (e.v < vd);
    e.hs = !((e.h >= hd + hf) && (e.h < hd + hf + hp));
    e.vs = !((e.v >= vd + vf) && (e.v < vd + vf + vp));
    e.ls = (e.h == 0);
    e.fs = (pos == 0);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = '{h: 0, v: 0, de: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0};
    return e;
  endfunction

  int   na, fca, nb, fcb;
  exp_t ea, eb;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      na = 0; fca = 0; ea = reset_exp();
    end else if (ifa.en) begin
      ea = decode(na, DEF_H_DISP, DEF_H_FP, DEF_H_PW, DEF_H_BP,
                  DEF_V_DISP, DEF_V_FP, DEF_V_PW);
      if (ea.fs) fca = (fca + 1) % 256;
      na = (na + 1) % A_FT;
    end else begin
      ea.de = 1'b0; ea.hs = 1'b1; ea.vs = 1'b1; ea.ls = 1'b0; ea.fs = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      nb = 0; fcb = 0; eb = reset_exp();
    end else if (ifb.en) begin
      eb = decode(nb, B_HD, B_HF, B_HP, B_HB, B_VD, B_VF, B_VP);
      if (eb.fs) fcb = (fcb + 1) % 4;
      nb = (nb + 1) % B_FT;
    end else begin
      eb.de = 1'b0; eb.hs = 1'b1; eb.vs = 1'b1; eb.ls = 1'b0; eb.fs = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("a_h_pos", ifa.h_pos, ea.h);
    chk("a_v_pos", ifa.v_pos, ea.v);
    chk("a_DE", ifa.video_DE, ea.de);
    chk("a_HS", ifa.video_HS, ea.hs);
    chk("a_VS", ifa.video_VS, ea.vs);
    chk("a_line_start", ifa.line_start, ea.ls);
    chk("a_frame_start", ifa.frame_start, ea.fs);
    chk("a_frame_count", ifa.frame_count, fca);
    chk("b_h_pos", ifb.h_pos, eb.h);
    chk("b_v_pos", ifb.v_pos, eb.v);
    chk("b_DE", ifb.video_DE, eb.de);
    chk("b_HS", ifb.video_HS, eb.hs);
    chk("b_VS", ifb.video_VS, eb.vs);
    chk("b_line_start", ifb.line_start, eb.ls);
    chk("b_frame_start", ifb.frame_start, eb.fs);
    chk("b_frame_count", ifb.frame_count, fcb);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos_a(input int h, input int v, input int budget, input string name);
    int k;
    k = 0;
    while (!(ifa.h_pos == h && ifa.v_pos == v) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, k < budget, 1);
  endtask

  task automatic run_a();
    int de_cnt, hs_cnt, hs_first, ls_extra, k;
    de_cnt = 0; hs_cnt = 0; hs_first = -1; ls_extra = 0;
    for (int i = 0; i < DEF_H_TOTAL; i++) begin
      if (i > 0 && ifa.line_start) ls_extra++;
      if (ifa.video_DE) de_cnt++;
      if (!ifa.video_HS) begin
        if (hs_cnt == 0) hs_first = int'(ifa.h_pos);
        hs_cnt++;
      end
      @(negedge clk);
    end
    chk("line_de_cycles", de_cnt, 720);
    chk("line_hs_cycles", hs_cnt, 62);
    chk("line_hs_first", hs_first, 736);
    chk("line_ls_extra", ls_extra, 0);
    chk("line_period_858", ifa.line_start, 1);
    chk("line_period_v", ifa.v_pos, 1);

    wait_pos_a(100, 3, 5000, "pause_reach_timeout");
    ifa.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause_h_hold", ifa.h_pos, 100);
      chk("pause_DE", ifa.video_DE, 0);
      chk("pause_HS", ifa.video_HS, 1);
      chk("pause_VS", ifa.video_VS, 1);
    end
    ifa.en = 1'b1;
    @(negedge clk);
    chk("resume_h", ifa.h_pos, 101);
    chk("resume_DE", ifa.video_DE, 1);
    k = 0;
    while (!ifa.line_start && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("resume_line_len", k, 757);
    chk("resume_next_v", ifa.v_pos, 4);

    wait_pos_a(400, 20, 20000, "reset_reach_timeout");
    #2 rst_a = 1'b0;
    #1;
    chk("areset_h", ifa.h_pos, 0);
    chk("areset_v", ifa.v_pos, 0);
    chk("areset_DE", ifa.video_DE, 0);
    chk("areset_HS", ifa.video_HS, 1);
    chk("areset_VS", ifa.video_VS, 1);
    chk("areset_fs", ifa.frame_start, 0);
    chk("areset_fc", ifa.frame_count, 0);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("restart_h", ifa.h_pos, 0);
    chk("restart_v", ifa.v_pos, 0);
    chk("restart_DE", ifa.video_DE, 1);
    chk("restart_fs", ifa.frame_start, 1);
    chk("restart_fc", ifa.frame_count, 1);
    repeat (50) @(negedge clk);
  endtask

  task automatic run_b();
    int fc_seq[5];
    int de_cnt, fs_extra, vs_bad;
    logic [7:0] vs_mask;
    logic prev_vs;
    fc_seq = '{1, 2, 3, 0, 1};
    de_cnt = 0; fs_extra = 0; vs_bad = 0; vs_mask = '0;
    prev_vs = ifb.video_VS;
    for (int f = 0; f < 5; f++) begin
      chk("b_frame_period_112", ifb.frame_start, 1);
      chk("b_fc_seq", ifb.frame_count, fc_seq[f]);
      for (int i = 0; i < B_FT; i++) begin
        if (i > 0 && ifb.frame_start) fs_extra++;
        if (f == 0) begin
          if (ifb.video_DE) de_cnt++;
          if (!ifb.video_VS) vs_mask[ifb.v_pos] = 1'b1;
        end
        if (ifb.video_VS != prev_vs && ifb.h_pos != 0) vs_bad++;
        prev_vs = ifb.video_VS;
        @(negedge clk);
      end
    end
    chk("b_de_per_frame", de_cnt, 32);
    chk("b_vs_lines", vs_mask, 8'h60);
    chk("b_vs_line_aligned", vs_bad, 0);
    chk("b_fs_extra", fs_extra, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.en = 1'b1;
    ifb.en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_h", ifa.h_pos, 0);
    chk("rst_v", ifa.v_pos, 0);
    chk("rst_DE", ifa.video_DE, 0);
    chk("rst_HS", ifa.video_HS, 1);
    chk("rst_VS", ifa.video_VS, 1);
    chk("rst_ls", ifa.line_start, 0);
    chk("rst_fs", ifa.frame_start, 0);
    chk("rst_fc", ifa.frame_count, 0);
    chk("rst_b_HS", ifb.video_HS, 1);
    chk("rst_b_VS", ifb.video_VS, 1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("first_h", ifa.h_pos, 0);
    chk("first_v", ifa.v_pos, 0);
    chk("first_DE", ifa.video_DE, 1);
    chk("first_ls", ifa.line_start, 1);
    chk("first_fs", ifa.frame_start, 1);
    chk("first_fc", ifa.frame_count, 1);
    fork
      run_a();
      run_b();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
